// File: rtl/switch_event_detector_pkg.sv
// Shared types and defaults for the switch event detector.
// Holds the FSM state encoding, the default limits and the counter width helper.
package switch_event_detector_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHeld = 2'd1,
        StLong = 2'd2
    } state_e;

    localparam int unsigned DefaultDebounceLimit  = 250000;
    localparam int unsigned DefaultLongPressLimit = 25000000;

    // A limit of 1 still needs a 1-bit counter to compare against zero.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/switch_event_detector.sv
// Debounces a mechanical switch and reports press, release, long press and short release.
// Every output comes straight from a flop; the raw input only reaches logic through sync_2ff.
module switch_event_detector
    import switch_event_detector_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT   = DefaultDebounceLimit,
    parameter int unsigned LONG_PRESS_LIMIT = DefaultLongPressLimit
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Long_Press,
    output logic o_Short_Release
);

    localparam int unsigned DbW   = cnt_width(DEBOUNCE_LIMIT);
    localparam int unsigned HoldW = cnt_width(LONG_PRESS_LIMIT);

    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_LIMIT - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_PRESS_LIMIT - 1);

    logic             sw_sync;
    logic             sw_q;
    logic [DbW-1:0]   db_cnt_q;
    logic [HoldW-1:0] hold_cnt_q;
    state_e           state_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic             short_q;
    logic             accept;
    logic             rise;
    logic             fall;

    sync_2ff u_sync (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .d     (i_Switch),
        .q     (sw_sync)
    );

    // The new level has persisted long enough and is taken on this edge.
    assign accept = (sw_sync != sw_q) && (db_cnt_q == DbLast);
    assign rise   = accept && sw_sync;
    assign fall   = accept && !sw_sync;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sw_q     <= 1'b0;
            db_cnt_q <= '0;
        end else if (sw_sync == sw_q) begin
            db_cnt_q <= '0;
        end else if (accept) begin
            sw_q     <= sw_sync;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            press_q   <= rise;
            release_q <= fall;
            long_q    <= 1'b0;
            short_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_q    <= StHeld;
                        hold_cnt_q <= '0;
                    end
                end
                StHeld: begin
                    // Release wins over a long press landing on the same edge.
                    if (fall) begin
                        state_q <= StIdle;
                        short_q <= 1'b1;
                    end else if (hold_cnt_q == HoldLast) begin
                        state_q <= StLong;
                        long_q  <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                StLong: begin
                    if (fall) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_Switch        = sw_q;
    assign o_Press         = press_q;
    assign o_Release       = release_q;
    assign o_Long_Press    = long_q;
    assign o_Short_Release = short_q;

endmodule

// File: tb/tb_switch_event_detector.sv
// Directed bench for switch_event_detector with DEBOUNCE_LIMIT=4, LONG_PRESS_LIMIT=10.
module tb_switch_event_detector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw = 1'b0;
    logic o_sw, o_press, o_rel, o_long, o_short;

    int errors = 0;
    int checks = 0;

    switch_event_detector #(
        .DEBOUNCE_LIMIT   (4),
        .LONG_PRESS_LIMIT (10)
    ) dut (
        .i_Clk           (clk),
        .i_Rst_L         (rst_n),
        .i_Switch        (sw),
        .o_Switch        (o_sw),
        .o_Press         (o_press),
        .o_Release       (o_rel),
        .o_Long_Press    (o_long),
        .o_Short_Release (o_short)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw    = 1'b0;
        repeat (3) step();
        checks++;
        if ({o_sw, o_press, o_rel, o_long, o_short} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {o_sw, o_press, o_rel, o_long, o_short});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({o_sw, o_press, o_rel, o_long, o_short} !== 5'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected 00000",
                     {o_sw, o_press, o_rel, o_long, o_short});
        end
    endtask

    // Leaves the bench right after the press edge (edge 6).
    task automatic test_press();
        sw = 1'b1;
        repeat (5) step();
        checks++;
        if ({o_sw, o_press} !== 2'b00) begin
            errors++;
            $display("FAIL press_edge5: got %b expected 00", {o_sw, o_press});
        end
        step();
        checks++;
        if ({o_sw, o_press} !== 2'b11) begin
            errors++;
            $display("FAIL press_edge6: got %b expected 11", {o_sw, o_press});
        end
    endtask

    task automatic test_long_press();
        int long_cnt = 0;
        int long_at = -1;
        int rel_cnt = 0;
        int rel_at = -1;
        int short_cnt = 0;
        int press_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (o_long) begin long_cnt++; long_at = k; end
            if (o_rel) rel_cnt++;
            if (o_press) press_cnt++;
        end
        checks++;
        if (long_cnt !== 1) begin
            errors++;
            $display("FAIL long_count: got %0d expected 1", long_cnt);
        end
        checks++;
        if (long_at !== 10) begin
            errors++;
            $display("FAIL long_offset: got %0d expected 10", long_at);
        end
        checks++;
        if (rel_cnt !== 0 || press_cnt !== 0) begin
            errors++;
            $display("FAIL long_hold_pulses: got rel=%0d press=%0d expected 0 0",
                     rel_cnt, press_cnt);
        end
        checks++;
        if (o_sw !== 1'b1) begin
            errors++;
            $display("FAIL long_hold_level: got %b expected 1", o_sw);
        end
        sw = 1'b0;
        long_cnt = 0;
        rel_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (o_rel) begin rel_cnt++; rel_at = k; end
            if (o_short) short_cnt++;
            if (o_long) long_cnt++;
        end
        checks++;
        if (rel_cnt !== 1 || rel_at !== 6) begin
            errors++;
            $display("FAIL long_release: got count=%0d at=%0d expected 1 at 6",
                     rel_cnt, rel_at);
        end
        checks++;
        if (short_cnt !== 0 || long_cnt !== 0) begin
            errors++;
            $display("FAIL long_release_extra: got short=%0d long=%0d expected 0 0",
                     short_cnt, long_cnt);
        end
        checks++;
        if (o_sw !== 1'b0) begin
            errors++;
            $display("FAIL long_release_level: got %b expected 0", o_sw);
        end
    endtask

    // Input high for edges 1..5 keeps the debounced level high for 5 cycles.
    task automatic test_short_press();
        int press_at = -1;
        int rel_at = -1;
        int short_at = -1;
        int long_cnt = 0;
        sw = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (o_press) press_at = k;
            if (o_rel) rel_at = k;
            if (o_short) short_at = k;
            if (o_long) long_cnt++;
            if (k == 5) sw = 1'b0;
        end
        checks++;
        if (press_at !== 6) begin
            errors++;
            $display("FAIL short_press_at: got %0d expected 6", press_at);
        end
        checks++;
        if (rel_at !== 11) begin
            errors++;
            $display("FAIL short_release_at: got %0d expected 11", rel_at);
        end
        checks++;
        if (short_at !== 11) begin
            errors++;
            $display("FAIL short_pulse_at: got %0d expected 11", short_at);
        end
        checks++;
        if (long_cnt !== 0) begin
            errors++;
            $display("FAIL short_no_long: got %0d expected 0", long_cnt);
        end
    endtask

    task automatic test_glitch();
        logic any_sw = 1'b0;
        int pulses = 0;
        sw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            any_sw |= o_sw;
            pulses += int'(o_press) + int'(o_rel) + int'(o_long) + int'(o_short);
            sw = ((k + 1) <= 3) || ((k + 1) >= 5 && (k + 1) <= 7);
        end
        checks++;
        if (any_sw !== 1'b0) begin
            errors++;
            $display("FAIL glitch_level: got %b expected 0", any_sw);
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL glitch_pulses: got %0d expected 0", pulses);
        end
    endtask

    task automatic test_reset_during_hold();
        int press_at = -1;
        int rel_cnt = 0;
        sw = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (o_press) press_at = k;
        end
        checks++;
        if (press_at !== 6) begin
            errors++;
            $display("FAIL hold_press_at: got %0d expected 6", press_at);
        end
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_sw, o_press, o_rel, o_long, o_short} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: got %b expected 00000",
                     {o_sw, o_press, o_rel, o_long, o_short});
        end
        repeat (2) begin
            step();
            rel_cnt += int'(o_rel) + int'(o_short);
        end
        rst_n = 1'b1;
        press_at = -1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (o_press) press_at = k;
            rel_cnt += int'(o_rel) + int'(o_short);
        end
        checks++;
        if (rel_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_release: got %0d expected 0", rel_cnt);
        end
        checks++;
        if (press_at !== 6) begin
            errors++;
            $display("FAIL repress_at: got %0d expected 6", press_at);
        end
        sw = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        test_reset();
        test_press();
        test_long_press();
        test_short_press();
        test_glitch();
        test_reset_during_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
